// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter and its baud-rate select between N_REQ byte
//   requesters. The block picks a requester round-robin and latches its byte
//   onto the transmitter data bus. It then pulses tx_start and waits for a
//   rising edge on tx_done. If no edge arrives before TIMEOUT_CYC cycles, it
//   aborts the frame. In either case it acknowledges the winning requester.
//
// Ports (all on sysclk rising edge, rst synchronous active-high)
//   req         in  N_REQ    level request per requester, held until ack
//   req_data    in  8*N_REQ  byte per requester, slice i = [8*i+7:8*i]
//   sel_in      in  3        requested baud select, sampled only while idle
//   ack         out N_REQ    one-cycle pulse when requester's frame ends
//   busy        out 1        high whenever the FSM is not idle
//   grant_id    out 3        requester currently owning the transmitter
//   tx_dbus     out 8        byte to transmitter, stable from START to ACK
//   tx_start    out 1        one-cycle transmit start pulse
//   tx_done     in  1        transmitter done (level or pulse, rise used)
//   tx_sel      out 3        baud select to brg/transmitter
//   timeout_err out 1        one-cycle pulse when a frame was aborted
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int TO_W        = 18
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [2:0]         sel_in,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic [7:0]         tx_dbus,
  output logic               tx_start,
  input  logic               tx_done,
  output logic [2:0]         tx_sel,
  output logic               timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      LAST_ID = 3'(N_REQ - 1);

  logic [1:0]      state;
  logic [2:0]      rr_ptr;
  logic            done_q;
  logic [TO_W-1:0] timer;
  logic            done_rise;
  logic [2:0]      winner;

  // First requesting index at or after ptr, scanning with wrap-around.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r,
                                         input logic [2:0]       ptr);
    logic [2:0] w;
    logic       found;
    int         idx;
    w     = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && r[idx]) begin
        w     = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] id);
    return (id == LAST_ID) ? 3'd0 : id + 3'd1;
  endfunction

  // A tx_done that was already high before WAIT is not a rise.
  // done_q tracks it every cycle, so a stale level is ignored.
  assign done_rise = tx_done & ~done_q;
  assign winner    = rr_pick(req, rr_ptr);
  assign busy      = (state != IDLE);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 3'd0;
      done_q      <= 1'b0;
      timer       <= '0;
      ack         <= '0;
      grant_id    <= 3'd0;
      tx_dbus     <= 8'h00;
      tx_start    <= 1'b0;
      tx_sel      <= 3'b000;
      timeout_err <= 1'b0;
    end else begin
      done_q      <= tx_done;
      tx_start    <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // The baud select only follows sel_in between frames.
          tx_sel <= sel_in;
          if (|req) begin
            grant_id <= winner;
            tx_dbus  <= req_data[8*int'(winner) +: 8];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A done edge takes priority over a timeout in the same cycle.
          if (done_rise) begin
            ack   <= N_REQ'(1) << grant_id;
            state <= ACK;
          end else if (timer == TO_LAST) begin
            ack         <= N_REQ'(1) << grant_id;
            timeout_err <= 1'b1;
            state       <= ACK;
          end
        end
        ACK: begin
          rr_ptr <= next_ptr(grant_id);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Drives uart_tx_arbiter with directed and randomized frames. It acts as
//   the transmitter, which answers tx_start with a tx_done pulse after a
//   chosen delay. Every output is compared with a transaction-level model of
//   the arbitration and timing rules.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 120;

  logic           sysclk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [2:0]     sel_in = '0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [2:0]     grant_id;
  logic [7:0]     tx_dbus;
  logic           tx_start;
  logic [2:0]     tx_sel;
  logic           timeout_err;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TO),
    .TO_W        (8)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .sel_in      (sel_in),
    .ack         (ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .tx_dbus     (tx_dbus),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .tx_sel      (tx_sel),
    .timeout_err (timeout_err)
  );

  always #5 sysclk = ~sysclk;

  int         n_vec = 0;
  int         n_err = 0;
  int         rr_m = 0;
  logic [7:0] exp_db = 8'h00;
  logic [2:0] exp_sel = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester closest to the pointer in the forward (wrapping) direction.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (i - ptr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic check_reset_vals();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_dbus", 32'(tx_dbus), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_sel", 32'(tx_sel), 0);
    chk("rst_terr", 32'(timeout_err), 0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    tx_done = 1'b0;
    @(negedge sysclk);
    check_reset_vals();
    rst    = 1'b0;
    rr_m   = 0;
    exp_db = 8'h00;
  endtask

  // Called at a negedge while idle, with req already set (nonzero).
  // Returns at the negedge of the idle cycle following the ack.
  // d: WAIT cycle in which tx_done is raised (beyond TO means never).
  // stale: tx_done held high from START through WAIT cycle 'stale'.
  // mutate: scramble req/req_data/sel_in mid-frame.
  task automatic frame(input int d, input int stale, input bit mutate);
    int           w;
    int           ack_j;
    bit           to;
    bit           prev;
    logic [N-1:0] eack;
    w = model_pick(req, rr_m);
    if (w < 0) begin
      $display("FAIL bench_req: got 0 expected nonzero request");
      n_err++;
      return;
    end
    exp_db  = req_data[8*w +: 8];
    exp_sel = sel_in;
    eack    = N'(1) << w;
    @(negedge sysclk);
    chk("start", 32'(tx_start), 1);
    chk("grant", 32'(grant_id), 32'(w));
    chk("dbus", 32'(tx_dbus), 32'(exp_db));
    chk("sel", 32'(tx_sel), 32'(exp_sel));
    chk("busy_start", 32'(busy), 1);
    tx_done = (stale > 0);
    prev    = tx_done;
    ack_j   = 0;
    to      = 1'b0;
    for (int j = 1; j <= TO + 2; j++) begin
      @(negedge sysclk);
      if (j == ack_j) begin
        chk("ack", 32'(ack), 32'(eack));
        chk("terr", 32'(timeout_err), 32'(to));
        chk("busy_ack", 32'(busy), 1);
        chk("start_ack", 32'(tx_start), 0);
        chk("dbus_ack", 32'(tx_dbus), 32'(exp_db));
        tx_done = 1'b0;
        break;
      end
      chk("ack_wait", 32'(ack), 0);
      chk("terr_wait", 32'(timeout_err), 0);
      chk("start_wait", 32'(tx_start), 0);
      chk("busy_wait", 32'(busy), 1);
      chk("dbus_wait", 32'(tx_dbus), 32'(exp_db));
      chk("sel_wait", 32'(tx_sel), 32'(exp_sel));
      if (stale > 0 && j <= stale) tx_done = 1'b1;
      else                         tx_done = (j == d);
      if (ack_j == 0) begin
        if (tx_done && !prev) begin
          ack_j = j + 1;
        end else if (j == TO) begin
          ack_j = j + 1;
          to    = 1'b1;
        end
      end
      prev = tx_done;
      if (mutate && j == 2) begin
        req_data = $urandom;
        sel_in   = 3'($urandom);
        req      = N'($urandom);
      end
    end
    rr_m = (w + 1) % N;
    @(negedge sysclk);
    chk("busy_idle", 32'(busy), 0);
    chk("ack_idle", 32'(ack), 0);
    chk("start_idle", 32'(tx_start), 0);
    chk("terr_idle", 32'(timeout_err), 0);
    chk("dbus_idle", 32'(tx_dbus), 32'(exp_db));
    chk("sel_idle", 32'(tx_sel), 32'(exp_sel));
  endtask

  // No requests: the block stays idle and tx_sel follows sel_in every cycle.
  task automatic idle_cycles(input int n);
    logic [2:0] s;
    req = '0;
    for (int k = 0; k < n; k++) begin
      s      = 3'($urandom);
      sel_in = s;
      @(negedge sysclk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_start", 32'(tx_start), 0);
      chk("idle_ack", 32'(ack), 0);
      chk("idle_sel", 32'(tx_sel), 32'(s));
      chk("idle_dbus", 32'(tx_dbus), 32'(exp_db));
    end
  endtask

  initial begin
    int st;
    int d;
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    check_reset_vals();
    rst = 1'b0;
    idle_cycles(3);

    // Single requester, done 100 cycles after start.
    req      = 4'b0001;
    req_data = 32'h0000_0055;
    sel_in   = 3'd3;
    frame(100, 0, 1'b0);

    // Round-robin over all four, from a fresh pointer.
    do_reset();
    req      = 4'b1111;
    req_data = 32'hA3A2_A1A0;
    sel_in   = 3'd5;
    for (int k = 0; k < 5; k++) frame(3 + k, 0, 1'b0);

    // Fairness and wrap: grant 2, then 1001 gives 3, 0, 3.
    req = 4'b0100;
    frame(5, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      req = 4'b1001;
      frame(4, 0, 1'b0);
    end

    // Timeout, coincident done/timeout, and done just before timeout.
    req = 4'b0010;
    frame(TO + 1000, 0, 1'b0);
    req = 4'b0010;
    frame(TO, 0, 1'b0);
    req = 4'b0010;
    frame(TO - 1, 0, 1'b0);

    // Stale done through START, re-rise later; sel/data/req changed mid-frame.
    req = 4'b0100;
    frame(9, 3, 1'b1);

    // Reset in the middle of WAIT.
    req      = 4'b0001;
    req_data = 32'h1122_3344;
    @(negedge sysclk);
    chk("rst_test_start", 32'(tx_start), 1);
    repeat (5) @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
    check_reset_vals();
    rst    = 1'b0;
    rr_m   = 0;
    exp_db = 8'h00;
    req    = 4'b0110;
    frame(6, 0, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      req      = N'($urandom_range(1, 15));
      req_data = $urandom;
      sel_in   = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        st = $urandom_range(1, 4);
        d  = st + 2 + $urandom_range(0, TO);
      end else begin
        st = 0;
        d  = $urandom_range(1, TO + 8);
      end
      frame(d, st, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle_cycles(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1ms");
    $fatal(1);
  end

endmodule
